arb_requester: RTL and testbench

- Client-side agent for one req/gnt port of the 4-way fixed-priority arbiter.
- Local logic queues burst jobs, each a beat count. The block raises req, waits for gnt, and counts one beat per granted cycle.
- After the last beat it drops req and waits for the arbiter to withdraw gnt before requesting again.
- One instance sits on each of req_0..req_3 / gnt_0..gnt_3.

---
 rtl/arb_requester.sv | 175 +++++++++++++++++
 tb/tb_arb_requester.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/arb_requester.sv
// Requester agent for one req/gnt port of the fixed-priority arbiter: queues burst jobs and counts granted beats.
// Optional abort-on-timeout path is compiled in when ARB_REQ_TIMEOUT_EN is defined.
module arb_requester #(
   parameter int LEN_W   = 4,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64,
   parameter int GAP     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             job_valid,
   input  logic [LEN_W-1:0] job_len,
   output logic             job_ready,
   input  logic             gnt,
   output logic             req,
   output logic             beat,
   output logic             beat_last,
   output logic             busy,
   output logic             timeout_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int GAP_W = $clog2(GAP + 1) + 1;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_OWN, S_RELEASE, S_GAP} state_t;

   state_t             state, state_n;
   logic [LEN_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [LEN_W-1:0]   rem, rem_n, head;
   logic [GAP_W-1:0]   gap_cnt, gap_n;
   logic               full, empty, push, pop;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign job_ready = !full;
   assign push      = job_valid && !full;
   // IDLE refuses to pop while gnt is still high, which also covers a reset taken mid-burst
   assign pop       = (state == S_IDLE) && !empty && !gnt;
   assign head      = mem[rd_ptr];

   assign beat      = gnt && ((state == S_REQ) || (state == S_OWN));
   assign beat_last = beat && (rem == LEN_W'(1));
   assign busy      = (state != S_IDLE) || !empty;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= job_len;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (pop && !push)
            count <= count - CNT_W'(1);
      end
   end

`ifdef ARB_REQ_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT) + 1;
   logic [WAIT_W-1:0] wait_cnt, wait_n;
   logic              abort;
`endif

   always_comb begin
      state_n = state;
      rem_n   = rem;
      gap_n   = gap_cnt;
`ifdef ARB_REQ_TIMEOUT_EN
      wait_n  = wait_cnt;
      abort   = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (pop) begin
               rem_n   = (head == '0) ? LEN_W'(1) : head;
               state_n = S_REQ;
`ifdef ARB_REQ_TIMEOUT_EN
               wait_n  = '0;
`endif
            end
         end
         S_REQ: begin
            if (gnt) begin
               if (rem == LEN_W'(1)) begin
                  state_n = S_RELEASE;
               end else begin
                  rem_n   = rem - LEN_W'(1);
                  state_n = S_OWN;
               end
            end else begin
`ifdef ARB_REQ_TIMEOUT_EN
               if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                  abort   = 1'b1;
                  state_n = S_RELEASE;
               end else begin
                  wait_n = wait_cnt + WAIT_W'(1);
               end
`endif
            end
         end
         S_OWN: begin
            if (gnt) begin
               if (rem == LEN_W'(1))
                  state_n = S_RELEASE;
               else
                  rem_n = rem - LEN_W'(1);
            end else begin
               state_n = S_REQ;
`ifdef ARB_REQ_TIMEOUT_EN
               wait_n  = '0;
`endif
            end
         end
         // Arbiter may keep gnt high a couple of cycles after req drops; those are not beats
         S_RELEASE: begin
            if (!gnt) begin
               if (GAP > 0) begin
                  state_n = S_GAP;
                  gap_n   = '0;
               end else begin
                  state_n = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt == GAP_W'(GAP - 1))
               state_n = S_IDLE;
            else
               gap_n = gap_cnt + GAP_W'(1);
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         rem     <= '0;
         gap_cnt <= '0;
         req     <= 1'b0;
      end else begin
         state   <= state_n;
         rem     <= rem_n;
         gap_cnt <= gap_n;
         req     <= (state_n == S_REQ) || (state_n == S_OWN);
      end
   end

`ifdef ARB_REQ_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         wait_cnt    <= wait_n;
         timeout_err <= abort;
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: per-cycle vectors of {req,beat,beat_last,busy,job_ready,timeout_err}.
// The timeout scenario follows ARB_REQ_TIMEOUT_EN.
module tb_arb_requester;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       job_valid = 1'b0;
   logic [3:0] job_len = 4'd0;
   logic       gnt = 1'b0;
   logic       job_ready, req, beat, beat_last, busy, timeout_err;

   int vecCount = 0;
   int errCount = 0;

   localparam logic [5:0] IDLE0 = 6'b000010;
   localparam logic [5:0] PEND  = 6'b000110;
   localparam logic [5:0] WAITG = 6'b100110;
   localparam logic [5:0] BEAT  = 6'b110110;
   localparam logic [5:0] LAST  = 6'b111110;
   localparam logic [5:0] TOUT  = 6'b000111;

   arb_requester #(.LEN_W(4), .DEPTH(4), .TIMEOUT(8), .GAP(1)) dut (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_len(job_len),
      .job_ready(job_ready), .gnt(gnt), .req(req), .beat(beat),
      .beat_last(beat_last), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Drive one cycle's inputs just after the rising edge, then settle to the falling edge
   task automatic applyStimulus(input logic r, input logic v, input logic [3:0] l, input logic g);
      @(posedge clk);
      #1;
      rst = r;
      job_valid = v;
      job_len = l;
      gnt = g;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      vecCount++;
      if (obs !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
      end
   endtask

   task automatic runVector(input string tag, input logic r, input logic v, input logic [3:0] l,
                            input logic g, input logic [5:0] exp);
      applyStimulus(r, v, l, g);
      checkOutput(tag, {req, beat, beat_last, busy, job_ready, timeout_err}, exp);
   endtask

   initial begin
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      runVector("reset",    0, 0, 0, 0, IDLE0);

      // single job, len 3, grant two cycles after req
      runVector("s1.push",  0, 1, 3, 0, IDLE0);
      runVector("s1.pop",   0, 0, 0, 0, PEND);
      runVector("s1.req0",  0, 0, 0, 0, WAITG);
      runVector("s1.req1",  0, 0, 0, 0, WAITG);
      runVector("s1.beat1", 0, 0, 0, 1, BEAT);
      runVector("s1.beat2", 0, 0, 0, 1, BEAT);
      runVector("s1.beat3", 0, 0, 0, 1, LAST);
      runVector("s1.rel0",  0, 0, 0, 1, PEND);
      runVector("s1.rel1",  0, 0, 0, 1, PEND);
      runVector("s1.rel2",  0, 0, 0, 0, PEND);
      runVector("s1.gap",   0, 0, 0, 0, PEND);
      runVector("s1.idle",  0, 0, 0, 0, IDLE0);

      // zero length counts as one beat
      runVector("s2.push",  0, 1, 0, 0, IDLE0);
      runVector("s2.pop",   0, 0, 0, 0, PEND);
      runVector("s2.beat",  0, 0, 0, 1, LAST);
      runVector("s2.rel",   0, 0, 0, 0, PEND);
      runVector("s2.gap",   0, 0, 0, 0, PEND);
      runVector("s2.idle",  0, 0, 0, 0, IDLE0);

      // back-to-back jobs (2,2), gnt lingers two cycles after req falls
      runVector("s3.push1", 0, 1, 2, 0, IDLE0);
      runVector("s3.push2", 0, 1, 2, 0, PEND);
      runVector("s3.a1",    0, 0, 0, 1, BEAT);
      runVector("s3.a2",    0, 0, 0, 1, LAST);
      runVector("s3.rel0",  0, 0, 0, 1, PEND);
      runVector("s3.rel1",  0, 0, 0, 1, PEND);
      runVector("s3.rel2",  0, 0, 0, 0, PEND);
      runVector("s3.gap",   0, 0, 0, 0, PEND);
      runVector("s3.pop2",  0, 0, 0, 0, PEND);
      runVector("s3.b1",    0, 0, 0, 1, BEAT);
      runVector("s3.b2",    0, 0, 0, 1, LAST);
      runVector("s3.rel",   0, 0, 0, 0, PEND);
      runVector("s3.gap2",  0, 0, 0, 0, PEND);
      runVector("s3.idle",  0, 0, 0, 0, IDLE0);

      // grant lost for three cycles after beat 2 of 4
      runVector("s4.push",  0, 1, 4, 0, IDLE0);
      runVector("s4.pop",   0, 0, 0, 0, PEND);
      runVector("s4.beat1", 0, 0, 0, 1, BEAT);
      runVector("s4.beat2", 0, 0, 0, 1, BEAT);
      runVector("s4.lost0", 0, 0, 0, 0, WAITG);
      runVector("s4.lost1", 0, 0, 0, 0, WAITG);
      runVector("s4.lost2", 0, 0, 0, 0, WAITG);
      runVector("s4.beat3", 0, 0, 0, 1, BEAT);
      runVector("s4.beat4", 0, 0, 0, 1, LAST);
      runVector("s4.rel",   0, 0, 0, 0, PEND);
      runVector("s4.gap",   0, 0, 0, 0, PEND);
      runVector("s4.idle",  0, 0, 0, 0, IDLE0);

      // grant never arrives for a len-2 job
      runVector("s5.push",  0, 1, 2, 0, IDLE0);
      runVector("s5.pop",   0, 0, 0, 0, PEND);
`ifdef ARB_REQ_TIMEOUT_EN
      for (int i = 0; i < 8; i++)
         runVector($sformatf("s5.wait%0d", i), 0, 0, 0, 0, WAITG);
      runVector("s5.abort", 0, 0, 0, 0, TOUT);
      runVector("s5.gap",   0, 0, 0, 0, PEND);
      runVector("s5.idle",  0, 0, 0, 0, IDLE0);
`else
      for (int i = 0; i < 12; i++)
         runVector($sformatf("s5.hold%0d", i), 0, 0, 0, 0, WAITG);
      runVector("s5.beat1", 0, 0, 0, 1, BEAT);
      runVector("s5.beat2", 0, 0, 0, 1, LAST);
      runVector("s5.rel",   0, 0, 0, 0, PEND);
      runVector("s5.gap",   0, 0, 0, 0, PEND);
      runVector("s5.idle",  0, 0, 0, 0, IDLE0);
`endif

      // FIFO order: len 1 then len 2
      runVector("s6.push1", 0, 1, 1, 0, IDLE0);
      runVector("s6.push2", 0, 1, 2, 0, PEND);
      runVector("s6.a1",    0, 0, 0, 1, LAST);
      runVector("s6.rel",   0, 0, 0, 0, PEND);
      runVector("s6.gap",   0, 0, 0, 0, PEND);
      runVector("s6.pop2",  0, 0, 0, 0, PEND);
      runVector("s6.b1",    0, 0, 0, 1, BEAT);
      runVector("s6.b2",    0, 0, 0, 1, LAST);
      runVector("s6.rel2",  0, 0, 0, 0, PEND);
      runVector("s6.gap2",  0, 0, 0, 0, PEND);
      runVector("s6.idle",  0, 0, 0, 0, IDLE0);

      // fill the FIFO while gnt is low, then reset mid-burst
      runVector("s7.push1", 0, 1, 3, 0, IDLE0);
      runVector("s7.push2", 0, 1, 3, 0, PEND);
      runVector("s7.push3", 0, 1, 4, 0, WAITG);
      runVector("s7.push4", 0, 1, 5, 0, WAITG);
      runVector("s7.push5", 0, 1, 6, 0, WAITG);
      runVector("s7.full",  0, 1, 6, 0, 6'b100100);
      runVector("s7.beat1", 0, 1, 6, 1, 6'b110100);
      runVector("s7.rstc",  1, 0, 0, 1, 6'b110100);
      runVector("s7.after", 0, 1, 1, 1, IDLE0);
      runVector("s7.hold",  0, 0, 0, 1, PEND);
      runVector("s7.pop",   0, 0, 0, 0, PEND);
      runVector("s7.beat",  0, 0, 0, 1, LAST);
      runVector("s7.rel",   0, 0, 0, 0, PEND);
      runVector("s7.gap",   0, 0, 0, 0, PEND);
      runVector("s7.idle",  0, 0, 0, 0, IDLE0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
